lsu: RTL and testbench

Load/store unit between the execute stage and `data_memory`. It turns a core load/store request (byte address, RV32I funct3, store data) into the word address, byte mask, write enable and lane-aligned write data that `data_memory` needs. It turns `data_memory` read data into a sign- or zero-extended load result. Word-crossing misaligned accesses are split into two memory beats by a small FSM, and the core is stalled for one extra cycle.

---
 rtl/lsu.sv | 206 ++++++++++++++++++++
 tb/tb_lsu.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu : load/store unit between the execute stage and data_memory.
//
// Converts a core request (byte address, RV32I funct3, right-justified store
// data) into word address, byte mask, write enable and lane-aligned write
// data for data_memory.
//
// It also sign- or zero-extends the memory read data into the load result.
// Accesses that cross a word boundary are split into two memory beats by a
// two-state FSM, which stalls the core for one extra cycle.
//
// Compile-time option:
//   LSU_MISALIGN_EN  defined   -> word-crossing accesses are split (IDLE/BEAT2)
//                    undefined -> word-crossing accesses report err, no write
//
// Ports:
//   clk, rst_n      core clock (rising edge), asynchronous active-low reset
//   req_valid       a load/store is presented this cycle
//   req_we          1 = store, 0 = load
//   req_funct3      000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr        byte address (only [DMEM_W-1:0] used)
//   req_wdata       store data, right-justified
//   ld_data         extended load result (valid with done on a load)
//   done            access completes this cycle
//   stall           hold PC / pipeline registers this cycle
//   err             illegal funct3, or crossing access with splitting disabled
//   mem_addr        data_memory byte address (always word aligned)
//   mem_bmask       data_memory byte lane mask
//   mem_wr_en       data_memory write enable
//   mem_wdata       data_memory lane-aligned write data
//   mem_rdata       data_memory combinational read data of mem_addr
//   dbg_state       current FSM state (0 = IDLE, 1 = BEAT2)
//
// Handshake: a request is accepted whenever req_valid=1 in IDLE. done=1 marks
// the cycle the access finishes. While stall=1 the core keeps req_* stable;
// the second beat runs only from latched copies and ignores req_*.
// ---------------------------------------------------------------------------
module lsu #(
  parameter int DMEM_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic [31:0]       ld_data,
  output logic              done,
  output logic              stall,
  output logic              err,
  output logic [DMEM_W-1:0] mem_addr,
  output logic [3:0]        mem_bmask,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              dbg_state
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BEAT2 = 1'b1;

  // Low-order ones of the access size: B -> 0001, H -> 0011, W -> 1111.
  function automatic logic [3:0] f_ones(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   f_ones = 4'b0001;
      2'b01:   f_ones = 4'b0011;
      default: f_ones = 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] f_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   f_size = 3'd1;
      2'b01:   f_size = 3'd2;
      default: f_size = 3'd4;
    endcase
  endfunction

  // d holds the addressed byte/half already shifted down to bit 0.
  function automatic logic [31:0] f_extend(input logic [31:0] d, input logic [2:0] f3);
    case (f3)
      3'b000:  f_extend = {{24{d[7]}}, d[7:0]};
      3'b001:  f_extend = {{16{d[15]}}, d[15:0]};
      3'b100:  f_extend = {24'h000000, d[7:0]};
      3'b101:  f_extend = {16'h0000, d[15:0]};
      default: f_extend = d;
    endcase
  endfunction

  logic [1:0]        w_off;
  logic [2:0]        w_size;
  logic              w_legal;
  logic              w_cross;
  logic [7:0]        w_m8;
  logic [63:0]       w_wd64;
  logic [DMEM_W-3:0] w_word;
  logic              w_start_split;

  assign w_off   = req_addr[1:0];
  assign w_size  = f_size(req_funct3);
  assign w_word  = req_addr[DMEM_W-1:2];
  // Stores only have B/H/W; BU/HU are load-only encodings.
  assign w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                   (req_funct3 == 3'b010) ||
                   (!req_we && ((req_funct3 == 3'b100) || (req_funct3 == 3'b101)));
  assign w_cross = ({1'b0, w_off} + w_size) > 3'd4;
  // 64-bit intermediates: the upper half is what spills into the next word.
  assign w_m8    = {4'b0000, f_ones(req_funct3)} << w_off;
  assign w_wd64  = {32'h0, req_wdata} << {w_off, 3'b000};

`ifdef LSU_MISALIGN_EN
  logic [0:0]        r_state;
  logic [DMEM_W-3:0] r_hold_addr;
  logic [1:0]        r_hold_off;
  logic [2:0]        r_hold_f3;
  logic              r_hold_we;
  logic [31:0]       r_hold_wdata;
  logic [31:0]       r_lo_word;
  logic              w_beat2;
  logic [7:0]        w_hold_m8;
  logic [63:0]       w_rd64;
  logic              w_unused;

  assign w_beat2   = (r_state == S_BEAT2);
  assign w_hold_m8 = {4'b0000, f_ones(r_hold_f3)} << r_hold_off;
  // First-beat bytes sit in the low word, second-beat bytes in the high word.
  assign w_rd64    = {mem_rdata, r_lo_word} >> {r_hold_off, 3'b000};
  assign dbg_state = r_state;
  assign w_unused  = &{1'b0, req_addr[31:DMEM_W], w_m8[7:4], w_hold_m8[3:0],
                       w_rd64[63:32]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_hold_addr  <= '0;
      r_hold_off   <= 2'b00;
      r_hold_f3    <= 3'b000;
      r_hold_we    <= 1'b0;
      r_hold_wdata <= 32'h0;
      r_lo_word    <= 32'h0;
    end else if (w_beat2) begin
      r_state <= S_IDLE;
    end else if (w_start_split) begin
      r_state      <= S_BEAT2;
      // Word index wraps to 0 at the top of memory.
      r_hold_addr  <= w_word + {{(DMEM_W-3){1'b0}}, 1'b1};
      r_hold_off   <= w_off;
      r_hold_f3    <= req_funct3;
      r_hold_we    <= req_we;
      r_hold_wdata <= w_wd64[63:32];
      r_lo_word    <= mem_rdata;
    end
  end
`else
  logic w_unused;

  assign dbg_state = S_IDLE;
  assign w_unused  = &{1'b0, clk, rst_n, req_addr[31:DMEM_W], w_m8[7:4],
                       w_wd64[63:32], w_start_split};
`endif

  always_comb begin
    mem_addr      = {w_word, 2'b00};
    mem_bmask     = 4'b0000;
    mem_wr_en     = 1'b0;
    mem_wdata     = w_wd64[31:0];
    done          = 1'b0;
    stall         = 1'b0;
    err           = 1'b0;
    ld_data       = 32'h0;
    w_start_split = 1'b0;
`ifdef LSU_MISALIGN_EN
    if (w_beat2) begin
      mem_addr  = {r_hold_addr, 2'b00};
      mem_bmask = w_hold_m8[7:4];
      mem_wdata = r_hold_wdata;
      mem_wr_en = r_hold_we;
      done      = 1'b1;
      if (!r_hold_we) ld_data = f_extend(w_rd64[31:0], r_hold_f3);
    end else
`endif
    if (req_valid) begin
      if (!w_legal) begin
        err  = 1'b1;
        done = 1'b1;
      end else if (w_cross) begin
`ifdef LSU_MISALIGN_EN
        mem_bmask     = w_m8[3:0];
        mem_wr_en     = req_we;
        stall         = 1'b1;
        w_start_split = 1'b1;
`else
        err  = 1'b1;
        done = 1'b1;
`endif
      end else begin
        mem_bmask = w_m8[3:0];
        mem_wr_en = req_we;
        done      = 1'b1;
        if (!req_we) ld_data = f_extend(mem_rdata >> {w_off, 3'b000}, req_funct3);
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu : directed plus random checks of lsu against a byte-array model.
// The bench owns a byte-wide data_memory and a separate reference byte array;
// loads are predicted from the reference array using little-endian byte
// assembly and sign/zero extension, independent of any lane-mask logic.
// ---------------------------------------------------------------------------
module tb_lsu;

  localparam int DMEM_W = 11;
  localparam int MEM_BYTES = 1 << DMEM_W;
`ifdef LSU_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr, req_wdata;
  logic [31:0]       ld_data;
  logic              done, stall, err;
  logic [DMEM_W-1:0] mem_addr;
  logic [3:0]        mem_bmask;
  logic              mem_wr_en;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              dbg_state;

  always #5 clk = ~clk;

  lsu #(.DMEM_W(DMEM_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .ld_data(ld_data), .done(done), .stall(stall), .err(err),
    .mem_addr(mem_addr), .mem_bmask(mem_bmask), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- bench-side data_memory ----------------
  logic [7:0] tb_mem  [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];

  always_comb begin
    mem_rdata = 32'h0;
    for (int l = 0; l < 4; l++)
      mem_rdata[8*l +: 8] = tb_mem[int'({mem_addr[DMEM_W-1:2], 2'b00}) + l];
  end

  always @(posedge clk)
    if (mem_wr_en)
      for (int l = 0; l < 4; l++)
        if (mem_bmask[l]) tb_mem[int'({mem_addr[DMEM_W-1:2], 2'b00}) + l] <= mem_wdata[8*l +: 8];

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sz_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit legal_of(input logic we, input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) return 1'b1;
    if (!we && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit crosses(input logic [31:0] a, input logic [2:0] f3);
    return (int'(a[1:0]) + sz_of(f3)) > 4;
  endfunction

  function automatic bit exp_err_of(input logic we, input logic [2:0] f3, input logic [31:0] a);
    return !legal_of(we, f3) || (!MIS && crosses(a, f3));
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v;
    int          n;
    v = 32'h0;
    n = sz_of(f3);
    for (int i = 0; i < n; i++)
      v = v | (32'(ref_mem[(int'(a[DMEM_W-1:0]) + i) % MEM_BYTES]) << (8 * i));
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    for (int i = 0; i < sz_of(f3); i++)
      ref_mem[(int'(a[DMEM_W-1:0]) + i) % MEM_BYTES] = d[8*i +: 8];
  endtask

  // ---------------- driver ----------------
  logic [DMEM_W-1:0] c0_addr, c1_addr;
  logic [3:0]        c0_bmask, c1_bmask;
  logic [31:0]       c0_wdata, c1_wdata;
  logic              c0_wr, c1_wr, c0_stall;
  logic              got_done, got_err;
  logic [31:0]       got_ld;
  int                got_cycles;

  // Called at posedge+1; returns at posedge+1 with req_valid low.
  task automatic access(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    #1;
    c0_addr = mem_addr; c0_bmask = mem_bmask; c0_wdata = mem_wdata;
    c0_wr = mem_wr_en; c0_stall = stall;
    c1_addr = '0; c1_bmask = '0; c1_wdata = '0; c1_wr = 1'b0;
    got_cycles = 1;
    while (stall && got_cycles < 4) begin
      @(posedge clk); #2;
      got_cycles++;
      c1_addr = mem_addr; c1_bmask = mem_bmask; c1_wdata = mem_wdata; c1_wr = mem_wr_en;
    end
    got_done = done; got_err = err; got_ld = ld_data;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Full access checked against the model; the model is updated on stores.
  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
    bit e;
    int cyc;
    e   = exp_err_of(we, f3, a);
    cyc = (!e && crosses(a, f3)) ? 2 : 1;
    access(we, f3, a, d);
    chk({tag, "_err"},    32'(got_err),    32'(e));
    chk({tag, "_done"},   32'(got_done),   32'd1);
    chk({tag, "_cycles"}, 32'(got_cycles), 32'(cyc));
    chk({tag, "_stall0"}, 32'(c0_stall),   32'(cyc == 2));
    if (!we) chk({tag, "_ld"}, got_ld, e ? 32'h0 : model_load(a, f3));
    if (we && !e) model_store(a, f3, d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int diff;
    for (int i = 0; i < MEM_BYTES; i++) begin
      tb_mem[i]  = 8'((i * 37 + 11) & 255);
      ref_mem[i] = 8'((i * 37 + 11) & 255);
    end
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'hFFFF_F123; req_wdata = 32'h0;
    #3;
    chk("rst_addr",  32'(mem_addr),  32'h120);
    chk("rst_bmask", 32'(mem_bmask), 32'h0);
    chk("rst_wr",    32'(mem_wr_en), 32'h0);
    chk("rst_done",  32'(done),      32'h0);
    chk("rst_stall", 32'(stall),     32'h0);
    chk("rst_err",   32'(err),       32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // aligned word store / load
    run_op("sw10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    chk("sw10_bmask", 32'(c0_bmask), 32'hF);
    chk("sw10_addr",  32'(c0_addr),  32'h10);
    run_op("lw10", 1'b0, 3'd2, 32'h10, 32'h0);
    chk("lw10_ld", got_ld, 32'hDEADBEEF);

    // byte at lane 3, signed and unsigned
    run_op("sb13", 1'b1, 3'd0, 32'h13, 32'h80);
    chk("sb13_bmask", 32'(c0_bmask), 32'h8);
    chk("sb13_wdata_lane", c0_wdata & 32'hFF00_0000, 32'h8000_0000);
    run_op("lb13", 1'b0, 3'd0, 32'h13, 32'h0);
    chk("lb13_ld", got_ld, 32'hFFFF_FF80);
    run_op("lbu13", 1'b0, 3'd4, 32'h13, 32'h0);
    chk("lbu13_ld", got_ld, 32'h0000_0080);

    // non-crossing misaligned half completes in one cycle in both builds
    run_op("sh05", 1'b1, 3'd1, 32'h105, 32'hBEEF);
    chk("sh05_bmask", 32'(c0_bmask), 32'h6);
    run_op("lhu05", 1'b0, 3'd5, 32'h105, 32'h0);

    // word crossing store at 0x21
    run_op("sw21", 1'b1, 3'd2, 32'h21, 32'h11223344);
    chk("sw21_wr0",    32'(c0_wr),    32'(MIS));
    chk("sw21_bmask0", 32'(c0_bmask), MIS ? 32'hE : 32'h0);
`ifdef LSU_MISALIGN_EN
    chk("sw21_addr0",  32'(c0_addr),  32'h20);
    chk("sw21_wdata0", c0_wdata,      32'h22334400);
    chk("sw21_addr1",  32'(c1_addr),  32'h24);
    chk("sw21_bmask1", 32'(c1_bmask), 32'h1);
    chk("sw21_wdata1", c1_wdata,      32'h00000011);
    chk("sw21_wr1",    32'(c1_wr),    32'h1);
`endif
    run_op("lw21", 1'b0, 3'd2, 32'h21, 32'h0);
    chk("lw21_ld", got_ld, MIS ? 32'h11223344 : 32'h0);

    // top-of-memory wrap
    run_op("sb7ff", 1'b1, 3'd0, 32'h7FF, 32'hFE);
    run_op("sb000", 1'b1, 3'd0, 32'h000, 32'h7F);
    run_op("lh7ff", 1'b0, 3'd1, 32'h7FF, 32'h0);
    chk("lh7ff_ld", got_ld, MIS ? 32'h00007FFE : 32'h0);
`ifdef LSU_MISALIGN_EN
    chk("lh7ff_addr1", 32'(c1_addr), 32'h000);
`endif

    // crossing store at 0x31, and illegal encodings
    run_op("sw31", 1'b1, 3'd2, 32'h31, 32'hCAFEF00D);
    run_op("f3_011", 1'b0, 3'd3, 32'h40, 32'h0);
    run_op("sbu_st", 1'b1, 3'd4, 32'h40, 32'h55);
    chk("sbu_st_wr", 32'(c0_wr), 32'h0);
    run_op("f3_111", 1'b1, 3'd7, 32'h44, 32'h66);

`ifdef LSU_MISALIGN_EN
    // reset during BEAT2: beat 1 bytes stay, second word untouched
    run_op("pre40", 1'b1, 3'd2, 32'h40, 32'h01020304);
    run_op("pre44", 1'b1, 3'd2, 32'h44, 32'h05060708);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h41; req_wdata = 32'hAABBCCDD;
    #1;
    chk("rst41_stall0", 32'(stall), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    chk("rst41_state", 32'(dbg_state), 32'h0);
    chk("rst41_stall", 32'(stall),     32'h0);
    chk("rst41_wr",    32'(mem_wr_en), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    ref_mem[16'h41] = 8'hDD; ref_mem[16'h42] = 8'hCC; ref_mem[16'h43] = 8'hBB;
    run_op("lw40", 1'b0, 3'd2, 32'h40, 32'h0);
    chk("lw40_ld", got_ld, 32'hBBCCDD04);
    run_op("lw44", 1'b0, 3'd2, 32'h44, 32'h0);
    chk("lw44_ld", got_ld, 32'h05060708);
`endif

    // random traffic
    for (int k = 0; k < 200; k++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic        we;
      int          r;
      r  = $urandom_range(0, 11);
      f3 = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 8) ? 3'd2 : (r < 9) ? 3'd4 :
           (r < 10) ? 3'd5 : 3'(r - 7);
      we = 1'($urandom_range(0, 1));
      a  = $urandom;
      if ($urandom_range(0, 7) == 0) a[DMEM_W-1:2] = '1;
      run_op("rnd", we, f3, a, $urandom);
    end

    diff = 0;
    for (int i = 0; i < MEM_BYTES; i++)
      if (tb_mem[i] !== ref_mem[i]) diff++;
    chk("mem_image_diff", 32'(diff), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
